// File: rtl/ex_ctrl_pkg.sv
// Shared types and encodings for the EX-stage pipeline controller.
// Holds the FSM state enum, the operand-forwarding selects and the forwarding decode.
package ex_ctrl_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // MEM is younger than WB, so its result wins when both match.
   function automatic logic [1:0] fwd_decode(
      input logic [4:0] rs,
      input logic [4:0] mem_rd,
      input logic       mem_regwrite,
      input logic [4:0] wb_rd,
      input logic       wb_regwrite
   );
      if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rs))
         return FWD_MEM;
      else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/ex_stage_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush event counters.
// Counts one per cycle while inc is high and sticks at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (inc && (count != {CNT_W{1'b1}}))
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/ex_stage_ctrl.sv
// EX-stage hazard controller: operand forwarding, load-use stalls, branch flushes
// and multi-cycle operation hand-off, plus stall/flush event counters.
module ex_stage_ctrl
   import ex_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs2,
   input  logic             ex_valid,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_regwrite,
   input  logic             ex_memread,
   input  logic             ex_branch,
   input  logic             ex_zero,
   input  logic             ex_mc,
   input  logic             mc_done,
   input  logic [4:0]       mem_rd,
   input  logic             mem_regwrite,
   input  logic [4:0]       wb_rd,
   input  logic             wb_regwrite,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_write,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             exmem_bubble,
   output logic             pc_sel,
   output logic             mc_start,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             busy
);

   state_t state;
   state_t state_next;
   logic   mc_req;
   logic   br_taken;
   logic   lu_haz;
   logic   mc_start_dec;
   logic   unused_ex_regwrite;

   assign unused_ex_regwrite = ex_regwrite;

   assign fwd_a_sel = fwd_decode(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
   assign fwd_b_sel = fwd_decode(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);

   assign mc_req   = ex_valid & ex_mc;
   assign br_taken = ex_valid & ex_branch & ex_zero & ~ex_mc;
   assign lu_haz   = ex_valid & ex_memread & (ex_rd != 5'd0) & id_valid &
                     ((ex_rd == id_rs1) | (id_use_rs2 & (ex_rd == id_rs2)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= RUN;
      else
         state <= state_next;
   end

   always_comb begin
      state_next   = state;
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_write   = 1'b1;
      flush_ifid   = 1'b0;
      flush_idex   = 1'b0;
      exmem_bubble = 1'b0;
      pc_sel       = 1'b0;
      mc_start_dec = 1'b0;
      case (state)
         RUN: begin
            if (mc_req) begin
               mc_start_dec = 1'b1;
               pc_write     = 1'b0;
               ifid_write   = 1'b0;
               idex_write   = 1'b0;
               exmem_bubble = 1'b1;
               state_next   = MC_WAIT;
            end else if (br_taken) begin
               pc_sel     = 1'b1;
               flush_ifid = 1'b1;
               flush_idex = 1'b1;
            end else if (lu_haz) begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               flush_idex = 1'b1;
            end
         end
         MC_WAIT: begin
            if (mc_done) begin
               state_next = RUN;
            end else begin
               pc_write     = 1'b0;
               ifid_write   = 1'b0;
               idex_write   = 1'b0;
               exmem_bubble = 1'b1;
            end
         end
         default: state_next = RUN;
      endcase
   end

   // Gate the start pulse so a held mc request cannot fire it while in reset.
   assign mc_start = mc_start_dec & rst_n;
   assign busy     = (state == MC_WAIT);

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (~pc_write),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pc_sel),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Directed self-checking bench for ex_stage_ctrl, with a second 4-bit-counter
// instance sharing the same stimulus to exercise counter saturation.
module tb_ex_stage_ctrl;
   import ex_ctrl_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       id_valid, id_use_rs2;
   logic [4:0] id_rs1, id_rs2;
   logic       ex_valid;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic       ex_regwrite, ex_memread, ex_branch, ex_zero, ex_mc;
   logic       mc_done;
   logic [4:0] mem_rd, wb_rd;
   logic       mem_regwrite, wb_regwrite;

   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic        pc_write, ifid_write, idex_write;
   logic        flush_ifid, flush_idex, exmem_bubble, pc_sel, mc_start, busy;
   logic [15:0] stall_cnt, flush_cnt;

   logic [1:0]  s_fwd_a_sel, s_fwd_b_sel;
   logic        s_pc_write, s_ifid_write, s_idex_write;
   logic        s_flush_ifid, s_flush_idex, s_exmem_bubble, s_pc_sel, s_mc_start, s_busy;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   int checks = 0;
   int errors = 0;

   ex_stage_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs2(id_use_rs2),
      .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_branch(ex_branch),
      .ex_zero(ex_zero), .ex_mc(ex_mc), .mc_done(mc_done),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex), .exmem_bubble(exmem_bubble),
      .pc_sel(pc_sel), .mc_start(mc_start),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .busy(busy)
   );

   ex_stage_ctrl #(.CNT_W(4)) dut_small (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs2(id_use_rs2),
      .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_branch(ex_branch),
      .ex_zero(ex_zero), .ex_mc(ex_mc), .mc_done(mc_done),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
      .pc_write(s_pc_write), .ifid_write(s_ifid_write), .idex_write(s_idex_write),
      .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex), .exmem_bubble(s_exmem_bubble),
      .pc_sel(s_pc_sel), .mc_start(s_mc_start),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .busy(s_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after a rising edge; checks happen 2 units later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs2 = 0;
      ex_valid = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
      ex_regwrite = 0; ex_memread = 0; ex_branch = 0; ex_zero = 0; ex_mc = 0;
      mc_done = 0; mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
      checks++; if (flush_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_flush_cnt got %0d exp 0", flush_cnt); end
      checks++; if ({pc_write, ifid_write, idex_write} !== 3'b111) begin errors++; $display("[TB] FAIL reset_enables got %b exp 111", {pc_write, ifid_write, idex_write}); end
      checks++; if ({flush_ifid, flush_idex, exmem_bubble, pc_sel, mc_start} !== 5'b00000) begin errors++; $display("[TB] FAIL reset_flushes got %b exp 00000", {flush_ifid, flush_idex, exmem_bubble, pc_sel, mc_start}); end
   endtask

   task automatic test_forwarding();
      clear_inputs();
      ex_rs1 = 5'd5; ex_rs2 = 5'd5; mem_rd = 5'd5; wb_rd = 5'd5; mem_regwrite = 1; wb_regwrite = 1;
      #2;
      checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("[TB] FAIL fwd_a_mem_prio got %b exp 10", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("[TB] FAIL fwd_b_mem_prio got %b exp 10", fwd_b_sel); end
      mem_regwrite = 0; ex_rs2 = 5'd9;
      #2;
      checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("[TB] FAIL fwd_a_wb got %b exp 01", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("[TB] FAIL fwd_b_nomatch got %b exp 00", fwd_b_sel); end
      mem_regwrite = 1; mem_rd = 5'd9;
      #2;
      checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("[TB] FAIL fwd_b_mem got %b exp 10", fwd_b_sel); end
      ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
      #2;
      checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("[TB] FAIL fwd_a_x0 got %b exp 00", fwd_a_sel); end
      clear_inputs();
   endtask

   task automatic test_load_use();
      do_reset();
      // EX: lw x3 ; ID: add x4, x3, x1
      ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd3;
      id_valid = 1; id_rs1 = 5'd3; id_rs2 = 5'd1; id_use_rs2 = 1;
      #2;
      checks++; if ({pc_write, ifid_write, idex_write} !== 3'b001) begin errors++; $display("[TB] FAIL lu_enables got %b exp 001", {pc_write, ifid_write, idex_write}); end
      checks++; if ({flush_idex, flush_ifid, pc_sel} !== 3'b100) begin errors++; $display("[TB] FAIL lu_flush got %b exp 100", {flush_idex, flush_ifid, pc_sel}); end
      tick();
      ex_valid = 0; ex_memread = 0; ex_regwrite = 0; ex_rd = 5'd0;
      #2;
      checks++; if ({pc_write, flush_idex} !== 2'b10) begin errors++; $display("[TB] FAIL lu_one_cycle got %b exp 10", {pc_write, flush_idex}); end
      checks++; if (stall_cnt !== 16'd1) begin errors++; $display("[TB] FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
      ex_valid = 1; ex_memread = 1; ex_rd = 5'd0; id_rs1 = 5'd0;
      #2;
      checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL lu_rd0_nohaz got %b exp 1", pc_write); end
      ex_rd = 5'd1; id_rs1 = 5'd7; id_use_rs2 = 0;
      #2;
      checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL lu_rs2_unused got %b exp 1", pc_write); end
      clear_inputs();
   endtask

   task automatic test_branch();
      do_reset();
      ex_valid = 1; ex_branch = 1; ex_zero = 1;
      #2;
      checks++; if ({pc_sel, flush_ifid, flush_idex} !== 3'b111) begin errors++; $display("[TB] FAIL br_taken_flush got %b exp 111", {pc_sel, flush_ifid, flush_idex}); end
      checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL br_taken_pc_write got %b exp 1", pc_write); end
      tick();
      ex_valid = 0;
      #2;
      checks++; if ({pc_sel, flush_ifid, flush_idex} !== 3'b000) begin errors++; $display("[TB] FAIL br_one_cycle got %b exp 000", {pc_sel, flush_ifid, flush_idex}); end
      checks++; if (flush_cnt !== 16'd1) begin errors++; $display("[TB] FAIL br_flush_cnt got %0d exp 1", flush_cnt); end
      ex_valid = 1; ex_zero = 0;
      #2;
      checks++; if ({pc_sel, flush_ifid, flush_idex} !== 3'b000) begin errors++; $display("[TB] FAIL br_not_taken got %b exp 000", {pc_sel, flush_ifid, flush_idex}); end
      tick();
      #2;
      checks++; if (flush_cnt !== 16'd1) begin errors++; $display("[TB] FAIL br_not_taken_cnt got %0d exp 1", flush_cnt); end
      clear_inputs();
   endtask

   task automatic test_multicycle();
      int busy_cycles;
      int start_pulses;
      busy_cycles  = 0;
      start_pulses = 0;
      do_reset();
      ex_valid = 1; ex_mc = 1;
      #2;
      checks++; if ({mc_start, busy, exmem_bubble, pc_write} !== 4'b1010) begin errors++; $display("[TB] FAIL mc_issue got %b exp 1010", {mc_start, busy, exmem_bubble, pc_write}); end
      if (busy) busy_cycles++;
      if (mc_start) start_pulses++;
      tick();
      for (int i = 0; i < 6; i++) begin
         if (i == 5) mc_done = 1;
         #2;
         if (busy) busy_cycles++;
         if (mc_start) start_pulses++;
         if (i == 0) begin
            checks++; if ({pc_write, ifid_write, idex_write, exmem_bubble} !== 4'b0001) begin errors++; $display("[TB] FAIL mc_wait_hold got %b exp 0001", {pc_write, ifid_write, idex_write, exmem_bubble}); end
         end
         if (i == 5) begin
            checks++; if ({pc_write, ifid_write, idex_write, exmem_bubble} !== 4'b1110) begin errors++; $display("[TB] FAIL mc_release got %b exp 1110", {pc_write, ifid_write, idex_write, exmem_bubble}); end
         end
         tick();
      end
      clear_inputs();
      #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mc_back_to_run got %b exp 0", busy); end
      checks++; if (busy_cycles != 6) begin errors++; $display("[TB] FAIL mc_busy_cycles got %0d exp 6", busy_cycles); end
      checks++; if (start_pulses != 1) begin errors++; $display("[TB] FAIL mc_start_pulses got %0d exp 1", start_pulses); end
      checks++; if (stall_cnt !== 16'd6) begin errors++; $display("[TB] FAIL mc_stall_cnt got %0d exp 6", stall_cnt); end
      mc_done = 1;
      tick();
      #2;
      checks++; if ({busy, pc_write} !== 2'b01) begin errors++; $display("[TB] FAIL mc_done_in_run got %b exp 01", {busy, pc_write}); end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      do_reset();
      ex_valid = 1; ex_mc = 1; ex_branch = 1; ex_zero = 1; ex_memread = 1; ex_rd = 5'd3;
      id_valid = 1; id_rs1 = 5'd3;
      #2;
      checks++; if ({mc_start, pc_sel, flush_ifid, flush_idex, exmem_bubble} !== 5'b10001) begin errors++; $display("[TB] FAIL simul_mc_only got %b exp 10001", {mc_start, pc_sel, flush_ifid, flush_idex, exmem_bubble}); end
      tick();
      #2;
      checks++; if ({mc_start, pc_sel, flush_idex, busy} !== 4'b0001) begin errors++; $display("[TB] FAIL simul_wait got %b exp 0001", {mc_start, pc_sel, flush_idex, busy}); end
      mc_done = 1;
      tick();
      mc_done = 0; ex_mc = 0; ex_branch = 0;
      #2;
      checks++; if ({pc_write, ifid_write, flush_idex, busy} !== 4'b0010) begin errors++; $display("[TB] FAIL simul_lu_served got %b exp 0010", {pc_write, ifid_write, flush_idex, busy}); end
      checks++; if (flush_cnt !== 16'd0) begin errors++; $display("[TB] FAIL simul_flush_cnt got %0d exp 0", flush_cnt); end
      clear_inputs();
   endtask

   task automatic test_reset_mc_wait();
      do_reset();
      ex_valid = 1; ex_mc = 1;
      repeat (4) tick();
      #2;
      checks++; if ({busy, stall_cnt} !== {1'b1, 16'd4}) begin errors++; $display("[TB] FAIL rst_pre_busy_stall got %b/%0d exp 1/4", busy, stall_cnt); end
      rst_n = 0;
      #1;
      checks++; if ({busy, mc_start} !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_busy_start got %b exp 00", {busy, mc_start}); end
      checks++; if ({stall_cnt, flush_cnt} !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
      clear_inputs();
      tick();
      rst_n = 1;
      tick();
      #2;
      checks++; if ({busy, mc_start, stall_cnt} !== {2'b00, 16'd0}) begin errors++; $display("[TB] FAIL rst_after got %b%b/%0d exp 00/0", busy, mc_start, stall_cnt); end
   endtask

   task automatic test_saturation();
      do_reset();
      ex_valid = 1; ex_mc = 1;
      tick();
      ex_valid = 0; ex_mc = 0;
      repeat (19) tick();
      #2;
      checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("[TB] FAIL sat_small got %0d exp 15", s_stall_cnt); end
      checks++; if (stall_cnt !== 16'd20) begin errors++; $display("[TB] FAIL sat_wide got %0d exp 20", stall_cnt); end
      mc_done = 1;
      tick();
      mc_done = 0;
      #2;
      checks++; if ({busy, s_busy, s_stall_cnt} !== {2'b00, 4'd15}) begin errors++; $display("[TB] FAIL sat_after got %b%b/%0d exp 00/15", busy, s_busy, s_stall_cnt); end
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #3;
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch();
      test_multicycle();
      test_back_to_back();
      test_reset_mc_wait();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_stage_ctrl.md
EX_STAGE_CTRL -- requirements
Module: ex_stage_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, which sets the width of the event counters.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port id_valid / id_rs1 / id_rs2 / id_use_rs2, input, 1/5/5/1: the instruction in ID and its source registers.
REQ-005 SHALL have port ex_valid / ex_rs1 / ex_rs2 / ex_rd, input, 1/5/5/5: the instruction in EX.
REQ-006 SHALL have port ex_regwrite / ex_memread / ex_branch / ex_zero / ex_mc, input, 1 each: EX controls, ALU zero flag, and the multi-cycle-op flag.
REQ-007 SHALL have port mc_done, input, 1: completion from the multi-cycle unit.
REQ-008 SHALL have port mem_rd / mem_regwrite / wb_rd / wb_regwrite, input, 5/1/5/1: destinations in MEM and WB.
REQ-009 SHALL have port fwd_a_sel / fwd_b_sel, output, 2: select for the ALU operands (00 = regfile, 01 = WB, 10 = MEM).
REQ-010 SHALL have port pc_write / ifid_write / idex_write, output, 1: pipeline register enables.
REQ-011 SHALL have port flush_ifid / flush_idex / exmem_bubble, output, 1: bubble injection.
REQ-012 SHALL have port pc_sel, output, 1: 1 = load the branch target address into the PC.
REQ-013 SHALL have port mc_start, output, 1: one-cycle start pulse to the multi-cycle unit.
REQ-014 SHALL have port stall_cnt / flush_cnt, output, CNT_W: event counters.
REQ-015 SHALL have port busy, output, 1: high while in state MC_WAIT.

Function
REQ-016 SHALL compute fwd_a_sel combinationally in every state: 10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1; else 01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1; else 00.
REQ-017 SHALL compute fwd_b_sel identically to fwd_a_sel, using ex_rs2.
REQ-018 SHALL define the condition mc_req = ex_valid & ex_mc.
REQ-019 SHALL define the condition br_taken = ex_valid & ex_branch & ex_zero.
REQ-020 SHALL define the condition lu_haz = ex_valid & ex_memread & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | (id_use_rs2 & ex_rd==id_rs2)).
REQ-021 SHALL implement a two-state FSM, RUN and MC_WAIT, with Mealy outputs.
REQ-022 SHALL, by default (no condition active), drive all enables = 1 and all flush, bubble, pc_sel and mc_start outputs = 0.
REQ-023 SHALL, in RUN, apply the priorities mc_req > br_taken > lu_haz, acting on only one of them per cycle.
REQ-024 SHALL, in RUN with mc_req: drive mc_start=1, pc_write=ifid_write=idex_write=0 and exmem_bubble=1; next state MC_WAIT.
REQ-025 SHALL, in RUN with br_taken (and no mc_req): drive pc_sel=1, flush_ifid=1 and flush_idex=1 for one cycle; next state RUN.
REQ-026 SHALL, in RUN with lu_haz only: drive pc_write=ifid_write=0 and flush_idex=1 for exactly one cycle; next state RUN.
REQ-027 SHALL, in MC_WAIT with mc_done=0: hold all enables = 0 and exmem_bubble=1; mc_start=0; no branch or load-use action.
REQ-028 SHALL, in MC_WAIT with mc_done=1: release all enables to 1 with exmem_bubble=0 in the same cycle; next state RUN.
REQ-029 SHALL ignore mc_done while in RUN.
REQ-030 SHALL ignore ex_branch when ex_mc is also asserted.
REQ-031 SHALL increment stall_cnt in every cycle where pc_write=0, saturating at all-ones.
REQ-032 SHALL increment flush_cnt in every cycle where pc_sel=1, saturating at all-ones.

Reset
REQ-033 SHALL, on rst_n low, immediately force state = RUN, stall_cnt = 0, flush_cnt = 0, busy = 0 and mc_start = 0; other outputs follow the RUN decode.
REQ-034 SHALL, on reset asserted during MC_WAIT, abandon the pending operation without issuing mc_start again.
REQ-035 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Structure
REQ-036 SHALL place the FSM state enum and the fwd_*_sel encodings (FWD_RF, FWD_WB, FWD_MEM) in the shared package ex_ctrl_pkg.
REQ-037 SHALL implement both counters as instances of one sub-module, sat_counter (parameter CNT_W; inputs clk, rst_n, inc; output count).

Verification
REQ-038 SHALL cover forwarding priority: mem_rd=wb_rd=ex_rs1=5 with both regwrite flags set -> fwd_a_sel=10; then rd=0 with both regwrite flags set -> fwd_a_sel=00.
REQ-039 SHALL cover load-use: ex lw x3, id add x4,x3,x1 -> exactly one cycle of pc_write=0 and flush_idex=1, and stall_cnt goes 0->1.
REQ-040 SHALL cover branch: beq with ex_zero=1 -> pc_sel, flush_ifid and flush_idex high for one cycle, and flush_cnt=1; with ex_zero=0 -> no flush.
REQ-041 SHALL cover the multi-cycle op: mc_req, then mc_done after 5 cycles -> mc_start high for 1 cycle, busy high for 6 cycles, and stall_cnt=6.
REQ-042 SHALL cover simultaneous events: mc_req with br_taken and lu_haz -> only the mc action occurs; after return to RUN, a pending lu_haz is then served.
REQ-043 SHALL cover reset: rst_n low mid-MC_WAIT -> busy=0 and counters=0 immediately; with CNT_W=4 and 20 stalls -> stall_cnt=15.
